img_bool_packer: RTL and testbench

- Upstream feeder of the convolution/classification top. It accepts a raster-order 8-bit grayscale pixel stream and booleanizes each pixel against a programmable threshold.
- The resulting bits are packed into 512-bit beats in the bit order the image memory expects: bit index = row*WIDTH + col.
- Beats go out on a valid/ready stream, with the final beat zero-padded. A one-cycle pulse marks the end of each image.

---
 rtl/img_bool_packer.sv | 144 ++++++++++++++
 tb/tb_img_bool_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_bool_packer.sv
// Booleanizes a raster 8-bit pixel stream against a latched threshold and packs
// the bits into BEAT_W-wide words (bit = row*WIDTH + col), zero-padding the tail.
module img_bool_packer #(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int LANES  = 8,
    parameter int BEAT_W = 512,
    parameter int NBEATS = (WIDTH * HEIGHT + BEAT_W - 1) / BEAT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 img_start,
    input  logic [7:0]           threshold,
    input  logic [8*LANES-1:0]   s_pixel,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [BEAT_W-1:0]    m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 img_done,
    output logic                 len_err
);
    localparam int TOTAL  = WIDTH * HEIGHT;
    localparam int PIX_W  = $clog2(TOTAL + 1);
    localparam int FILL_W = $clog2(BEAT_W + 1);
    localparam int WC_W   = $clog2(NBEATS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic [7:0]        thr;
    logic [PIX_W-1:0]  pix_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic [BEAT_W-1:0] pack;
    logic [BEAT_W-1:0] hold_data;
    logic              hold_valid;
    logic [WC_W-1:0]   gen_cnt;
    logic [WC_W-1:0]   word_cnt;

    logic [LANES-1:0]  bits;
    logic [PIX_W-1:0]  pix_next;
    logic [FILL_W-1:0] fill_next;
    logic [BEAT_W-1:0] merged;
    logic [BEAT_W-1:0] gen_data;
    logic accept, out_free, consume, img_close, word_close, zero_gen, gen_word, last_done;

    always_comb begin
        bits = '0;
        for (int unsigned l = 0; l < LANES; l++)
            bits[l] = (s_pixel[8*l +: 8] >= thr);
    end

    assign s_ready    = (state == FILL) && !hold_valid;
    assign accept     = s_valid && s_ready;
    assign out_free   = !m_valid || m_ready;
    assign consume    = m_valid && m_ready;
    assign pix_next   = pix_cnt + PIX_W'(LANES);
    assign fill_next  = fill_cnt + FILL_W'(LANES);
    assign merged     = pack | (BEAT_W'(bits) << fill_cnt);
    assign img_close  = accept && (s_last || (pix_next == PIX_W'(TOTAL)));
    assign word_close = accept && ((fill_next == FILL_W'(BEAT_W)) || img_close);
    // Padding words are only generated once the real words have left the hold slot.
    assign zero_gen   = (state == DRAIN) && !hold_valid && (gen_cnt < WC_W'(NBEATS));
    assign gen_word   = word_close || zero_gen;
    assign gen_data   = word_close ? merged : '0;
    assign last_done  = (state == DRAIN) && consume && (word_cnt == WC_W'(NBEATS - 1));
    assign img_done   = last_done && !img_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            thr        <= '0;
            pix_cnt    <= '0;
            fill_cnt   <= '0;
            pack       <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            gen_cnt    <= '0;
            word_cnt   <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            len_err    <= 1'b0;
        end else if (img_start) begin
            state      <= FILL;
            thr        <= threshold;
            pix_cnt    <= '0;
            fill_cnt   <= '0;
            pack       <= '0;
            hold_valid <= 1'b0;
            gen_cnt    <= '0;
            word_cnt   <= '0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            len_err    <= 1'b0;
        end else if (state == FILL || state == DRAIN) begin
            if (hold_valid) begin
                if (out_free) begin
                    m_data     <= hold_data;
                    m_valid    <= 1'b1;
                    hold_valid <= 1'b0;
                end
            end else if (gen_word) begin
                gen_cnt <= gen_cnt + 1'b1;
                if (out_free) begin
                    m_data  <= gen_data;
                    m_valid <= 1'b1;
                end else begin
                    hold_data  <= gen_data;
                    hold_valid <= 1'b1;
                end
            end else if (consume) begin
                m_valid <= 1'b0;
            end

            if (consume)
                word_cnt <= word_cnt + 1'b1;

            if (accept) begin
                pix_cnt <= pix_next;
                if (word_close) begin
                    pack     <= '0;
                    fill_cnt <= '0;
                end else begin
                    pack     <= merged;
                    fill_cnt <= fill_next;
                end
                if (img_close) begin
                    state <= DRAIN;
                    if (s_last != (pix_next == PIX_W'(TOTAL)))
                        len_err <= 1'b1;
                end
            end

            if (last_done) begin
                state   <= DONE;
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_img_bool_packer.sv
// Directed-sequence bench with random pixel data; expected words come from a
// per-pixel reference model of the booleanize/raster-pack rules.
module tb_img_bool_packer;
    localparam int WIDTH  = 28;
    localparam int HEIGHT = 28;
    localparam int LANES  = 8;
    localparam int BEAT_W = 512;
    localparam int TOTAL  = WIDTH * HEIGHT;
    localparam int NBEATS = 2;
    localparam int FULL   = TOTAL / LANES;
    localparam int WBEATS = BEAT_W / LANES;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                img_start = 1'b0;
    logic [7:0]          threshold = '0;
    logic [8*LANES-1:0]  s_pixel = '0;
    logic                s_valid = 1'b0;
    logic                s_last = 1'b0;
    logic                s_ready;
    logic [BEAT_W-1:0]   m_data;
    logic                m_valid;
    logic                m_ready = 1'b1;
    logic                img_done;
    logic                len_err;

    logic [8*LANES-1:0]  beats [FULL];
    logic [BEAT_W-1:0]   got_q [$];
    int checks = 0;
    int failures = 0;

    img_bool_packer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .LANES(LANES), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rst(rst), .img_start(img_start), .threshold(threshold),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .img_done(img_done), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pixel(input int g);
        logic [8*LANES-1:0] b;
        b = beats[g / LANES];
        return b[8*(g % LANES) +: 8];
    endfunction

    function automatic logic [BEAT_W-1:0] model_word(input int w, input int n_recv, input logic [7:0] t);
        logic [BEAT_W-1:0] r;
        r = '0;
        for (int b = 0; b < BEAT_W; b++) begin
            int g;
            g = w * BEAT_W + b;
            if (g < n_recv * LANES) r[b] = (pixel(g) >= t);
        end
        return r;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < FULL; i++) beats[i] = {$urandom, $urandom};
    endtask

    task automatic pulse_start(input logic [7:0] t);
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
        img_start = 1'b1;
        threshold = t;
        @(negedge clk);
        img_start = 1'b0;
        threshold = ~t;
    endtask

    // mode 0: m_ready=1, mode 1: 200-cycle stall once word0 is valid, mode 2: random m_ready
    task automatic run_image(input string tag, input logic [7:0] t, input int n, input bit last_flag, input int mode);
        int bi, cyc, dones, stall_left, stall_acc, gaps, close_beat;
        bit lat_pending, held_v;
        logic [BEAT_W-1:0] held;
        bi = 0; cyc = 0; dones = 0; stall_left = 200; stall_acc = 0; gaps = 0;
        lat_pending = 1'b0; held_v = 1'b0; held = '0;
        close_beat = (n < WBEATS ? n : WBEATS) - 1;
        got_q.delete();
        pulse_start(t);
        while (cyc < 3000 && dones == 0) begin
            s_valid = (bi < n);
            s_pixel = (bi < n) ? beats[bi] : '0;
            s_last  = last_flag && (bi == n - 1);
            if (mode == 1) begin
                if ((m_valid || stall_left < 200) && stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else m_ready = 1'b1;
            end else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
            #1;
            if (lat_pending) begin
                check({tag, "_latency"}, m_valid, 1'b1);
                check({tag, "_latency_data"}, m_data, model_word(0, n, t));
                lat_pending = 1'b0;
            end
            if (mode == 1 && !m_ready) begin
                if (held_v) check({tag, "_stall_stable"}, m_data, held);
                held = m_data;
                held_v = 1'b1;
                if (s_valid && s_ready) stall_acc++;
                if (stall_left == 0) check({tag, "_stall_sready"}, s_ready, 1'b0);
            end
            if (mode == 0 && s_valid && !s_ready) gaps++;
            if (s_valid && s_ready) begin
                if (mode == 0 && bi == close_beat) lat_pending = 1'b1;
                bi++;
            end
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (img_done) begin
                dones++;
                check({tag, "_done_on_last"}, got_q.size(), NBEATS);
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, dones, 1);
        check({tag, "_accepted"}, bi, n);
        check({tag, "_nwords"}, got_q.size(), NBEATS);
        for (int w = 0; w < NBEATS; w++)
            if (w < got_q.size()) check($sformatf("%s_word%0d", tag, w), got_q[w], model_word(w, n, t));
        check({tag, "_len_err"}, len_err, !(last_flag && n == FULL));
        if (mode == 0) check({tag, "_no_gaps"}, gaps, 0);
        if (mode == 1) check({tag, "_stall_accepts"}, stall_acc, (n - WBEATS < WBEATS) ? n - WBEATS : WBEATS);
        s_valid = 1'b1;
        s_last = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        #1;
        check({tag, "_after_done"}, {img_done, m_valid, s_ready}, 3'b000);
        s_valid = 1'b0;
    endtask

    initial begin
        logic [BEAT_W-1:0] pw;
        logic [7:0] t;

        // reset state
        #3;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_img_done", img_done, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_s_ready", s_ready, 1'b0);

        // all-255 image, threshold 128
        for (int i = 0; i < FULL; i++) beats[i] = '1;
        run_image("ones", 8'd128, FULL, 1'b1, 0);
        if (got_q.size() == NBEATS) begin
            check("ones_w0_full", got_q[0], {BEAT_W{1'b1}});
            pw = got_q[1];
            check("ones_w1_bit271", pw[271], 1'b1);
            check("ones_w1_bit272", pw[272], 1'b0);
        end

        // equal-to-threshold gives 1, one below gives 0
        fill_random();
        beats[0][7:0]  = 8'd77;
        beats[0][15:8] = 8'd76;
        run_image("thr_eq", 8'd77, FULL, 1'b1, 0);
        if (got_q.size() > 0) begin
            pw = got_q[0];
            check("thr_eq_bit0", pw[0], 1'b1);
            check("thr_eq_bit1", pw[1], 1'b0);
        end

        // row parity image: bit g set iff row g/WIDTH is odd
        for (int g = 0; g < TOTAL; g++) beats[g / LANES][8*(g % LANES) +: 8] = ((g / WIDTH) % 2 == 1) ? 8'hFF : 8'h00;
        t = 8'($urandom_range(1, 255));
        run_image("parity", t, FULL, 1'b1, 0);
        for (int w = 0; w < NBEATS; w++) begin
            pw = '0;
            for (int b = 0; b < BEAT_W; b++)
                if (w * BEAT_W + b < TOTAL) pw[b] = ((w * BEAT_W + b) / WIDTH) % 2 == 1;
            if (w < got_q.size()) check($sformatf("parity_direct%0d", w), got_q[w], pw);
        end

        // output stall with the all-255 image
        for (int i = 0; i < FULL; i++) beats[i] = '1;
        run_image("stall", 8'd128, FULL, 1'b1, 1);

        // early s_last on beat 50
        fill_random();
        run_image("short", 8'($urandom), 50, 1'b1, 0);
        if (got_q.size() == NBEATS) check("short_w1_zero", got_q[1], '0);

        // full count reached without s_last
        fill_random();
        run_image("nolast", 8'($urandom), FULL, 1'b0, 0);

        // random backpressure
        fill_random();
        run_image("bp", 8'($urandom), FULL, 1'b1, 2);

        // restart via img_start at input beat 30
        fill_random();
        pulse_start(8'd200);
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_pixel = beats[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        fill_random();
        run_image("restart", 8'($urandom), FULL, 1'b1, 0);

        // async reset mid-image with a word in flight
        fill_random();
        pulse_start(8'd10);
        m_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            s_valid = 1'b1;
            s_pixel = beats[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        #1;
        check("pre_rst_m_valid", m_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {img_done, len_err, m_valid, s_ready}, 4'b0000);
        check("mid_rst_m_data", m_data, '0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        fill_random();
        run_image("post_rst", 8'($urandom), FULL, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
